// File: rtl/io_bus_pkg.sv
// io_bus_pkg: window offsets and STATUS register layout for io_bus_responder.
package io_bus_pkg;
    localparam logic [1:0] OFF_DATA   = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam int STS_TXF    = 0;
    localparam int STS_RXE    = 1;
    localparam int STS_TXOVF  = 2;
    localparam int STS_RXUDF  = 3;
    localparam int TXCNT_LSB  = 4;
    localparam int RXCNT_LSB  = 8;
    localparam int CNT_FIELD_W = 4;
endpackage

// File: rtl/io_bus_responder_if.sv
// io_bus_responder_if: CPU bus plus TX/RX stream signals of the I/O responder.
interface io_bus_responder_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 6
);
    logic                  bus_we;
    logic                  bus_re;
    logic [ADDR_WIDTH-1:0] bus_addr;
    logic [DATA_WIDTH-1:0] bus_wdata;
    logic [DATA_WIDTH-1:0] bus_rdata;
    logic                  bus_hit;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  rx_ready;

    modport master (
        output bus_we, bus_re, bus_addr, bus_wdata, tx_ready, rx_data, rx_valid,
        input  bus_rdata, bus_hit, tx_data, tx_valid, rx_ready
    );

    modport slave (
        input  bus_we, bus_re, bus_addr, bus_wdata, tx_ready, rx_data, rx_valid,
        output bus_rdata, bus_hit, tx_data, tx_valid, rx_ready
    );
endinterface

// File: rtl/io_bus_responder_sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO; push when full and pop when empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign full   = r_count == CW'(DEPTH);
    assign empty  = r_count == '0;
    assign count  = r_count;
    assign dout   = r_mem[r_rd_ptr];
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    // Storage is not reset: count and pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + AW'(w_push);
            r_rd_ptr <= r_rd_ptr + AW'(w_pop);
            r_count  <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end
endmodule

// File: rtl/io_bus_responder.sv
// io_bus_responder: 4-word memory-mapped window bridging CPU bus accesses to TX/RX FIFO streams.
module io_bus_responder
    import io_bus_pkg::*;
#(
    parameter int                      DATA_WIDTH = 16,
    parameter int                      ADDR_WIDTH = 6,
    parameter logic [ADDR_WIDTH-1:0]   IO_BASE    = 6'h3C,
    parameter int                      FIFO_DEPTH = 4
) (
    input logic              clk,
    input logic              rst,
    io_bus_responder_if.slave bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_WIDTH-3:0] BASE_HI = IO_BASE[ADDR_WIDTH-1:2];

    logic                  w_in_win;
    logic [1:0]            w_off;
    logic                  w_wr;
    logic                  w_rd;
    logic                  w_tx_push;
    logic                  w_tx_pop;
    logic                  w_tx_full;
    logic                  w_tx_empty;
    logic [CW-1:0]         w_tx_count;
    logic                  w_rx_push;
    logic                  w_rx_pop;
    logic                  w_rx_full;
    logic                  w_rx_empty;
    logic [CW-1:0]         w_rx_count;
    logic [DATA_WIDTH-1:0] w_rx_dout;
    logic                  w_tx_ovf_set;
    logic                  w_rx_udf_set;
    logic                  w_tx_ovf_clr;
    logic                  w_rx_udf_clr;
    logic [DATA_WIDTH-1:0] w_status;
    logic [DATA_WIDTH-1:0] w_rdata_nxt;
    logic                  r_tx_ovf;
    logic                  r_rx_udf;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_hit;

    // Base is 4-aligned, so the window is a match on the upper address bits.
    assign w_in_win = bus.bus_addr[ADDR_WIDTH-1:2] == BASE_HI;
    assign w_off    = bus.bus_addr[1:0];
    assign w_wr     = bus.bus_we && w_in_win;
    assign w_rd     = bus.bus_re && !bus.bus_we && w_in_win;

    assign w_tx_push    = w_wr && w_off == OFF_DATA && !w_tx_full;
    assign w_tx_ovf_set = w_wr && w_off == OFF_DATA && w_tx_full;
    assign w_tx_pop     = bus.tx_valid && bus.tx_ready;
    assign w_rx_pop     = w_rd && w_off == OFF_DATA && !w_rx_empty;
    assign w_rx_udf_set = w_rd && w_off == OFF_DATA && w_rx_empty;
    assign w_rx_push    = bus.rx_valid && bus.rx_ready;
    assign w_tx_ovf_clr = w_wr && w_off == OFF_STATUS && bus.bus_wdata[STS_TXOVF];
    assign w_rx_udf_clr = w_wr && w_off == OFF_STATUS && bus.bus_wdata[STS_RXUDF];

    sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_tx_push),
        .pop   (w_tx_pop),
        .din   (bus.bus_wdata),
        .dout  (bus.tx_data),
        .full  (w_tx_full),
        .empty (w_tx_empty),
        .count (w_tx_count)
    );

    sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_rx_push),
        .pop   (w_rx_pop),
        .din   (bus.rx_data),
        .dout  (w_rx_dout),
        .full  (w_rx_full),
        .empty (w_rx_empty),
        .count (w_rx_count)
    );

    assign bus.tx_valid  = !w_tx_empty;
    assign bus.rx_ready  = !w_rx_full;
    assign bus.bus_rdata = r_rdata;
    assign bus.bus_hit   = r_hit;

    always_comb begin
        w_status = '0;
        w_status[STS_TXF]   = w_tx_full;
        w_status[STS_RXE]   = w_rx_empty;
        w_status[STS_TXOVF] = r_tx_ovf;
        w_status[STS_RXUDF] = r_rx_udf;
        w_status[TXCNT_LSB +: CNT_FIELD_W] = CNT_FIELD_W'(w_tx_count);
        w_status[RXCNT_LSB +: CNT_FIELD_W] = CNT_FIELD_W'(w_rx_count);
    end

    assign w_rdata_nxt = (w_off == OFF_DATA)   ? (w_rx_empty ? '0 : w_rx_dout) :
                         (w_off == OFF_STATUS) ? w_status : '0;

    // Sticky flags: a set event in the same cycle overrides a write-1-to-clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_ovf <= 1'b0;
            r_rx_udf <= 1'b0;
            r_rdata  <= '0;
            r_hit    <= 1'b0;
        end else begin
            r_tx_ovf <= w_tx_ovf_set ? 1'b1 : (w_tx_ovf_clr ? 1'b0 : r_tx_ovf);
            r_rx_udf <= w_rx_udf_set ? 1'b1 : (w_rx_udf_clr ? 1'b0 : r_rx_udf);
            r_rdata  <= w_rd ? w_rdata_nxt : '0;
            r_hit    <= w_rd;
        end
    end
endmodule

// File: tb/tb_io_bus_responder.sv
// tb_io_bus_responder: directed-vector bench for io_bus_responder with hand-computed expectations.
module tb_io_bus_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    io_bus_responder_if #(.DATA_WIDTH(16), .ADDR_WIDTH(6)) bif ();

    io_bus_responder dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [5:0] a, input logic [15:0] d);
        bif.bus_we = 1'b1;
        bif.bus_addr = a;
        bif.bus_wdata = d;
        tick();
        bif.bus_we = 1'b0;
    endtask

    task automatic bus_rd(input logic [5:0] a, output logic [15:0] d, output logic h);
        bif.bus_re = 1'b1;
        bif.bus_addr = a;
        tick();
        bif.bus_re = 1'b0;
        d = bif.bus_rdata;
        h = bif.bus_hit;
    endtask

    logic [15:0] d;
    logic        h;

    initial begin
        bif.bus_we = 1'b0;
        bif.bus_re = 1'b0;
        bif.bus_addr = '0;
        bif.bus_wdata = '0;
        bif.tx_ready = 1'b0;
        bif.rx_data = '0;
        bif.rx_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_hit", 32'(bif.bus_hit), 32'd0);
        chk("rst_rdata", 32'(bif.bus_rdata), 32'd0);
        chk("rst_rx_ready", 32'(bif.rx_ready), 32'd1);
        chk("rst_tx_valid", 32'(bif.tx_valid), 32'd0);
        bus_rd(6'h3D, d, h);
        chk("status_idle", 32'(d), 32'h0002);
        chk("status_idle_hit", 32'(h), 32'd1);
        tick();
        chk("hit_drops", 32'(bif.bus_hit), 32'd0);

        bus_wr(6'h3C, 16'h1111);
        chk("tx_valid_after_push", 32'(bif.tx_valid), 32'd1);
        bus_wr(6'h3C, 16'h2222);
        chk("tx_head", 32'(bif.tx_data), 32'h1111);
        bus_rd(6'h3D, d, h);
        chk("status_tx2", 32'(d), 32'h0022);
        bif.tx_ready = 1'b1;
        chk("tx_out0", 32'(bif.tx_data), 32'h1111);
        tick();
        chk("tx_out1", 32'(bif.tx_data), 32'h2222);
        chk("tx_valid1", 32'(bif.tx_valid), 32'd1);
        tick();
        chk("tx_drained", 32'(bif.tx_valid), 32'd0);
        bif.tx_ready = 1'b0;

        for (int i = 1; i <= 5; i++) bus_wr(6'h3C, 16'(i));
        bus_rd(6'h3D, d, h);
        chk("status_ovf", 32'(d), 32'h0047);
        bus_wr(6'h3D, 16'h0004);
        bus_rd(6'h3D, d, h);
        chk("status_ovf_clr", 32'(d), 32'h0043);
        bif.tx_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("tx_drain%0d", i), 32'(bif.tx_data), 32'(i));
            tick();
        end
        chk("tx_drop5", 32'(bif.tx_valid), 32'd0);
        bif.tx_ready = 1'b0;

        bif.rx_valid = 1'b1;
        bif.rx_data = 16'hA5A5;
        tick();
        bif.rx_data = 16'h5A5A;
        tick();
        bif.rx_valid = 1'b0;
        bus_rd(6'h3C, d, h);
        chk("rx_rd0", 32'(d), 32'hA5A5);
        chk("rx_rd0_hit", 32'(h), 32'd1);
        bus_rd(6'h3C, d, h);
        chk("rx_rd1", 32'(d), 32'h5A5A);
        bus_rd(6'h3C, d, h);
        chk("rx_udf_data", 32'(d), 32'd0);
        chk("rx_udf_hit", 32'(h), 32'd1);
        bus_rd(6'h3D, d, h);
        chk("status_udf", 32'(d), 32'h000A);
        bus_wr(6'h3D, 16'h0008);
        bus_rd(6'h3D, d, h);
        chk("status_udf_clr", 32'(d), 32'h0002);

        bif.rx_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bif.rx_data = 16'h0100 + 16'(i);
            tick();
        end
        chk("rx_full_ready", 32'(bif.rx_ready), 32'd0);
        bif.rx_data = 16'h0200;
        bus_rd(6'h3C, d, h);
        chk("rx_full_pop", 32'(d), 32'h0100);
        chk("rx_ready_reopen", 32'(bif.rx_ready), 32'd1);
        tick();
        bif.rx_valid = 1'b0;
        bus_rd(6'h3D, d, h);
        chk("status_rx4", 32'(d), 32'h0400);
        bus_rd(6'h3C, d, h);
        chk("rx_seq1", 32'(d), 32'h0101);
        bus_rd(6'h3C, d, h);
        chk("rx_seq2", 32'(d), 32'h0102);
        bus_rd(6'h3C, d, h);
        chk("rx_seq3", 32'(d), 32'h0103);
        bus_rd(6'h3C, d, h);
        chk("rx_seq4", 32'(d), 32'h0200);

        bus_rd(6'h05, d, h);
        chk("outside_hit", 32'(h), 32'd0);
        chk("outside_data", 32'(d), 32'd0);
        bus_rd(6'h3E, d, h);
        chk("reserved_hit", 32'(h), 32'd1);
        chk("reserved_data", 32'(d), 32'd0);
        bus_wr(6'h3F, 16'hFFFF);
        bif.bus_we = 1'b1;
        bif.bus_re = 1'b1;
        bif.bus_addr = 6'h3D;
        bif.bus_wdata = 16'h0000;
        tick();
        bif.bus_we = 1'b0;
        bif.bus_re = 1'b0;
        chk("we_re_hit", 32'(bif.bus_hit), 32'd0);
        bus_rd(6'h3D, d, h);
        chk("status_after_rsvd", 32'(d), 32'h0002);

        bus_wr(6'h3C, 16'hBEEF);
        bus_wr(6'h3C, 16'hCAFE);
        bif.rx_valid = 1'b1;
        bif.rx_data = 16'h7777;
        bif.tx_ready = 1'b1;
        tick();
        bif.rx_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bif.tx_ready = 1'b0;
        chk("rst_mid_tx_valid", 32'(bif.tx_valid), 32'd0);
        bus_rd(6'h3D, d, h);
        chk("rst_mid_status", 32'(d), 32'h0002);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
